axi_stream_width_conv: RTL and testbench

- Packet-aware AXI-stream gearbox between two `if_axi_stream` interfaces of different data widths.
- Up-converts (narrow→wide) by packing beats, or down-converts (wide→narrow) by splitting beats.
- Preserves sop/eop/mod/err/ctl semantics on both sides.
- Sits between narrow host/PCIe-side streams and wide core-side datapaths (e.g. 8-byte ↔ 64-byte).

---
 rtl/common_pkg.sv | 13 +
 rtl/if_axi_stream.sv | 20 ++
 rtl/axi_stream_reg.sv | 53 +++++
 rtl/axi_stream_width_conv.sv | 174 +++++++++++++++++
 tb/tb_axi_stream_width_conv.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Helpers shared by the stream blocks: effective byte count of a beat and
// integer ceiling division.
package common_pkg;

  function automatic int eff_byts(input logic eop, input int mod, input int byts);
    return (eop && mod != 0) ? mod : byts;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Packet-framed valid/ready stream: sop/eop framing, mod = valid bytes on
// the eop beat (0 means full word), sticky err and sideband ctl.
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
);
  localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [DAT_BYTS*8-1:0] dat;
  logic [MOD_BITS-1:0]   mod;
  logic [CTL_BITS-1:0]   ctl;

  modport source (output val, sop, eop, err, dat, mod, ctl, input rdy);
  modport sink   (input val, sop, eop, err, dat, mod, ctl, output rdy);
endinterface

// File: rtl/axi_stream_reg.sv
// One-deep registered stream slice: loads when empty or draining, holds all
// fields stable while the consumer stalls.
module axi_stream_reg #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  in_val,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_err,
  input  logic [DAT_BYTS*8-1:0] in_dat,
  input  logic [MOD_BITS-1:0]   in_mod,
  input  logic [CTL_BITS-1:0]   in_ctl,
  output logic                  in_rdy,
  output logic                  out_val,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_err,
  output logic [DAT_BYTS*8-1:0] out_dat,
  output logic [MOD_BITS-1:0]   out_mod,
  output logic [CTL_BITS-1:0]   out_ctl,
  input  logic                  out_rdy
);

  assign in_rdy = !out_val || out_rdy;

  // output register stage
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      out_val <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_err <= 1'b0;
      out_dat <= '0;
      out_mod <= '0;
      out_ctl <= '0;
    end else if (in_val && in_rdy) begin
      out_val <= 1'b1;
      out_sop <= in_sop;
      out_eop <= in_eop;
      out_err <= in_err;
      out_dat <= in_dat;
      out_mod <= in_mod;
      out_ctl <= in_ctl;
    end else if (out_rdy) begin
      out_val <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_stream_width_conv.sv
// Packet-aware stream gearbox: packs narrow beats into wide words (up) or
// splits wide beats into narrow ones (down), little-endian byte lanes.
module axi_stream_width_conv
  import common_pkg::*;
#(
  parameter int IN_BYTS  = 8,
  parameter int OUT_BYTS = 64,
  parameter int CTL_BITS = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  if_axi_stream.sink    i_axi,
  if_axi_stream.source  o_axi
);

  localparam int RATIO     = (OUT_BYTS > IN_BYTS) ? OUT_BYTS / IN_BYTS : IN_BYTS / OUT_BYTS;
  localparam bit UP        = OUT_BYTS > IN_BYTS;
  localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OUT_MOD_W = (OUT_BYTS > 1) ? $clog2(OUT_BYTS) : 1;

  // Input ready stays low through reset and for the edge that releases it.
  logic rdy_en_p0;

  always_ff @(posedge i_clk) begin
    if (!i_rst) rdy_en_p0 <= 1'b0;
    else        rdy_en_p0 <= 1'b1;
  end

  if (IN_BYTS == OUT_BYTS) begin : g_pass
    logic slc_rdy;

    assign i_axi.rdy = rdy_en_p0 && slc_rdy;

    axi_stream_reg #(.DAT_BYTS(OUT_BYTS), .CTL_BITS(CTL_BITS), .MOD_BITS(OUT_MOD_W)) u_reg (
      .i_clk(i_clk), .i_rst(i_rst),
      .in_val(i_axi.val && rdy_en_p0), .in_sop(i_axi.sop), .in_eop(i_axi.eop),
      .in_err(i_axi.err), .in_dat(i_axi.dat), .in_mod(i_axi.mod), .in_ctl(i_axi.ctl),
      .in_rdy(slc_rdy),
      .out_val(o_axi.val), .out_sop(o_axi.sop), .out_eop(o_axi.eop), .out_err(o_axi.err),
      .out_dat(o_axi.dat), .out_mod(o_axi.mod), .out_ctl(o_axi.ctl), .out_rdy(o_axi.rdy)
    );

  end else if (UP) begin : g_up
    logic [CNT_W-1:0]      cnt_p0;
    logic [OUT_BYTS*8-1:0] acc_p0;
    logic                  sop_acc_p0;
    logic                  err_acc_p0;
    logic [CTL_BITS-1:0]   ctl_acc_p0;
    logic [OUT_BYTS*8-1:0] word;
    logic                  w_sop;
    logic                  w_err;
    logic [CTL_BITS-1:0]   w_ctl;
    logic [OUT_MOD_W-1:0]  w_mod;
    logic                  last_beat;
    logic                  close;
    logic                  acc_en;
    logic                  slc_rdy;

    assign last_beat = (cnt_p0 == CNT_W'(RATIO - 1));
    assign close     = last_beat || i_axi.eop;
    // Beats that only fill the accumulator need no room downstream.
    assign i_axi.rdy = rdy_en_p0 && (slc_rdy || !close);
    assign acc_en    = i_axi.val && i_axi.rdy;

    always_comb begin
      word = acc_p0;
      word[int'(cnt_p0)*IN_BYTS*8 +: IN_BYTS*8] = i_axi.dat;
      w_sop = (cnt_p0 == '0) ? i_axi.sop : sop_acc_p0;
      w_ctl = (cnt_p0 == '0) ? i_axi.ctl : ctl_acc_p0;
      w_err = err_acc_p0 | i_axi.err;
      w_mod = OUT_MOD_W'((int'(cnt_p0) * IN_BYTS +
                          eff_byts(i_axi.eop, int'(i_axi.mod), IN_BYTS)) % OUT_BYTS);
    end

    // accumulator stage; err stays sticky until the packet's eop word
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        cnt_p0     <= '0;
        acc_p0     <= '0;
        sop_acc_p0 <= 1'b0;
        err_acc_p0 <= 1'b0;
        ctl_acc_p0 <= '0;
      end else if (acc_en) begin
        if (close) begin
          cnt_p0     <= '0;
          acc_p0     <= '0;
          sop_acc_p0 <= 1'b0;
          err_acc_p0 <= i_axi.eop ? 1'b0 : w_err;
        end else begin
          cnt_p0     <= cnt_p0 + CNT_W'(1);
          acc_p0     <= word;
          sop_acc_p0 <= w_sop;
          err_acc_p0 <= w_err;
          ctl_acc_p0 <= w_ctl;
        end
      end
    end

    axi_stream_reg #(.DAT_BYTS(OUT_BYTS), .CTL_BITS(CTL_BITS), .MOD_BITS(OUT_MOD_W)) u_reg (
      .i_clk(i_clk), .i_rst(i_rst),
      .in_val(acc_en && close), .in_sop(w_sop), .in_eop(i_axi.eop),
      .in_err(w_err), .in_dat(word), .in_mod(w_mod), .in_ctl(w_ctl),
      .in_rdy(slc_rdy),
      .out_val(o_axi.val), .out_sop(o_axi.sop), .out_eop(o_axi.eop), .out_err(o_axi.err),
      .out_dat(o_axi.dat), .out_mod(o_axi.mod), .out_ctl(o_axi.ctl), .out_rdy(o_axi.rdy)
    );

  end else begin : g_down
    localparam int IN_MOD_W = (IN_BYTS > 1) ? $clog2(IN_BYTS) : 1;

    logic [IN_BYTS*8-1:0] hold_dat_p0;
    logic [IN_MOD_W-1:0]  hold_mod_p0;
    logic                 hold_sop_p0;
    logic                 hold_eop_p0;
    logic                 hold_err_p0;
    logic [CTL_BITS-1:0]  hold_ctl_p0;
    logic                 full_p0;
    logic                 err_pend_p0;
    logic [CNT_W-1:0]     idx_p0;
    int                   eff;
    int                   last_idx;
    logic                 at_last;
    logic                 o_hs;
    logic                 i_acc;

    always_comb begin
      eff      = eff_byts(hold_eop_p0, int'(hold_mod_p0), IN_BYTS);
      last_idx = hold_eop_p0 ? ceil_div(eff, OUT_BYTS) - 1 : RATIO - 1;
    end

    assign at_last   = (int'(idx_p0) == last_idx);
    assign o_hs      = o_axi.val && o_axi.rdy;
    assign i_axi.rdy = rdy_en_p0 && (!full_p0 || (o_hs && at_last));
    assign i_acc     = i_axi.val && i_axi.rdy;

    assign o_axi.val = full_p0;
    assign o_axi.dat = hold_dat_p0[int'(idx_p0)*OUT_BYTS*8 +: OUT_BYTS*8];
    assign o_axi.sop = hold_sop_p0 && (idx_p0 == '0);
    assign o_axi.eop = hold_eop_p0 && at_last;
    assign o_axi.mod = (hold_eop_p0 && at_last) ? OUT_MOD_W'(eff % OUT_BYTS) : '0;
    assign o_axi.err = hold_err_p0 && at_last;
    assign o_axi.ctl = hold_ctl_p0;

    // hold stage; errors on earlier beats ride along to the eop beat's hold
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        hold_dat_p0 <= '0;
        hold_mod_p0 <= '0;
        hold_sop_p0 <= 1'b0;
        hold_eop_p0 <= 1'b0;
        hold_err_p0 <= 1'b0;
        hold_ctl_p0 <= '0;
        full_p0     <= 1'b0;
        err_pend_p0 <= 1'b0;
        idx_p0      <= '0;
      end else begin
        if (o_hs) idx_p0 <= at_last ? '0 : idx_p0 + CNT_W'(1);
        if (i_acc) begin
          hold_dat_p0 <= i_axi.dat;
          hold_mod_p0 <= i_axi.mod;
          hold_sop_p0 <= i_axi.sop;
          hold_eop_p0 <= i_axi.eop;
          hold_err_p0 <= i_axi.eop && (i_axi.err || err_pend_p0);
          hold_ctl_p0 <= i_axi.ctl;
          err_pend_p0 <= !i_axi.eop && (i_axi.err || err_pend_p0);
          full_p0     <= 1'b1;
        end else if (o_hs && at_last) begin
          full_p0 <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_width_conv.sv
// Directed bench for the stream gearbox: up 8->64, down 64->8 and up 8->32.
module tb_axi_stream_width_conv;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  if_axi_stream #(.DAT_BYTS(8),  .CTL_BITS(8)) upi ();
  if_axi_stream #(.DAT_BYTS(64), .CTL_BITS(8)) upo ();
  if_axi_stream #(.DAT_BYTS(64), .CTL_BITS(8)) dni ();
  if_axi_stream #(.DAT_BYTS(8),  .CTL_BITS(8)) dno ();
  if_axi_stream #(.DAT_BYTS(8),  .CTL_BITS(8)) tpi ();
  if_axi_stream #(.DAT_BYTS(32), .CTL_BITS(8)) tpo ();

  axi_stream_width_conv #(.IN_BYTS(8), .OUT_BYTS(64), .CTL_BITS(8)) u_up (
    .i_clk(i_clk), .i_rst(i_rst), .i_axi(upi), .o_axi(upo));
  axi_stream_width_conv #(.IN_BYTS(64), .OUT_BYTS(8), .CTL_BITS(8)) u_dn (
    .i_clk(i_clk), .i_rst(i_rst), .i_axi(dni), .o_axi(dno));
  axi_stream_width_conv #(.IN_BYTS(8), .OUT_BYTS(32), .CTL_BITS(8)) u_tp (
    .i_clk(i_clk), .i_rst(i_rst), .i_axi(tpi), .o_axi(tpo));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] seq_bytes(input int base, input int n);
    logic [511:0] d;
    d = '0;
    for (int j = 0; j < n; j++) d[j*8 +: 8] = 8'((base + j) & 255);
    return d;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [511:0] tmp;
  logic [511:0] exp_w;
  logic [78:0]  snap;
  logic [78:0]  prev_snap;
  logic         prev_stall;
  logic         in_hs;
  int           ib;
  int           nb;
  int           nout;
  int           idle;

  initial begin
    upi.val = 1'b1; upi.sop = 1'b1; upi.eop = 1'b0; upi.err = 1'b1;
    upi.dat = 64'hDEAD_BEEF_0123_4567; upi.mod = '0; upi.ctl = 8'hFF;
    upo.rdy = 1'b1;
    dni.val = 1'b0; dni.sop = 1'b0; dni.eop = 1'b0; dni.err = 1'b0;
    dni.dat = '0; dni.mod = '0; dni.ctl = '0;
    dno.rdy = 1'b1;
    tpi.val = 1'b0; tpi.sop = 1'b0; tpi.eop = 1'b0; tpi.err = 1'b0;
    tpi.dat = '0; tpi.mod = '0; tpi.ctl = '0;
    tpo.rdy = 1'b1;

    // ---- reset held for 5 cycles with input valid
    repeat (5) @(posedge i_clk);
    #1;
    chk("rst_up_oval", upo.val, 0);
    chk("rst_up_irdy", upi.rdy, 0);
    chk("rst_up_ofields", {upo.sop, upo.eop, upo.err, upo.mod, upo.ctl}, 0);
    chk("rst_up_odat", upo.dat, 0);
    chk("rst_dn_oval", dno.val, 0);
    chk("rst_dn_ofields", {dno.sop, dno.eop, dno.err, dno.mod, dno.ctl, dno.dat}, 0);
    chk("rst_dn_irdy", dni.rdy, 0);
    i_rst   = 1'b1;
    upi.val = 1'b0;
    #1;
    chk("rst_rdy_before_edge", upi.rdy, 0);
    step();
    chk("rst_up_rdy_rise", upi.rdy, 1);
    chk("rst_dn_rdy_rise", dni.rdy, 1);
    chk("rst_tp_rdy_rise", tpi.rdy, 1);

    // ---- up 8->64, full word of 8 beats
    for (int k = 0; k < 8; k++) begin
      upi.val = 1'b1;
      upi.dat = {8{8'(k + 1)}};
      upi.sop = (k == 0);
      upi.eop = (k == 7);
      upi.mod = '0;
      upi.err = 1'b0;
      upi.ctl = (k == 0) ? 8'hA5 : 8'h00;
      @(negedge i_clk);
      chk("up_full_irdy", upi.rdy, 1);
      if (k == 7) chk("up_full_early", upo.val, 0);
      step();
    end
    upi.val = 1'b0;
    exp_w = '0;
    for (int l = 0; l < 64; l++) exp_w[l*8 +: 8] = 8'(l / 8 + 1);
    chk("up_full_val", upo.val, 1);
    chk("up_full_sop_eop", {upo.sop, upo.eop}, 2'b11);
    chk("up_full_mod", upo.mod, 0);
    chk("up_full_err", upo.err, 0);
    chk("up_full_ctl", upo.ctl, 8'hA5);
    chk("up_full_dat", upo.dat, exp_w);
    step();
    chk("up_full_drain", upo.val, 0);

    // ---- up 8->64, 20-byte packet, err on a middle beat
    tmp = seq_bytes(16, 20);
    for (int k = 0; k < 3; k++) begin
      upi.val = 1'b1;
      upi.dat = tmp[k*64 +: 64];
      upi.sop = (k == 0);
      upi.eop = (k == 2);
      upi.mod = (k == 2) ? 3'd4 : 3'd0;
      upi.err = (k == 1);
      upi.ctl = (k == 0) ? 8'h33 : 8'hFF;
      step();
    end
    upi.val = 1'b0;
    chk("up_part_val", upo.val, 1);
    chk("up_part_sop_eop", {upo.sop, upo.eop}, 2'b11);
    chk("up_part_mod", upo.mod, 20);
    chk("up_part_err", upo.err, 1);
    chk("up_part_ctl", upo.ctl, 8'h33);
    chk("up_part_dat", upo.dat, tmp);
    step();
    chk("up_part_drain", upo.val, 0);

    // ---- up 8->64, single-beat packets under output stall
    upo.rdy = 1'b0;
    upi.val = 1'b1; upi.sop = 1'b1; upi.eop = 1'b1; upi.err = 1'b0;
    upi.dat = 64'h0000_0000_00C3_C2C1; upi.mod = 3'd3; upi.ctl = 8'h77;
    @(negedge i_clk);
    chk("up_stall_rdy_empty", upi.rdy, 1);
    step();
    chk("up_single_val", upo.val, 1);
    chk("up_single_mod", upo.mod, 3);
    chk("up_single_dat", upo.dat, 512'hC3_C2C1);
    upi.dat = 64'h0000_00D5_D4D3_D2D1; upi.mod = 3'd5; upi.ctl = 8'h88;
    @(negedge i_clk);
    chk("up_stall_rdy", upi.rdy, 0);
    step();
    chk("up_stall_hold", {upo.val, upo.mod, upo.ctl}, {1'b1, 6'd3, 8'h77});
    upo.rdy = 1'b1;
    @(negedge i_clk);
    chk("up_stall_rdy_release", upi.rdy, 1);
    step();
    upi.val = 1'b0;
    chk("up_second_val", upo.val, 1);
    chk("up_second_fields", {upo.mod, upo.ctl, upo.sop, upo.eop}, {6'd5, 8'h88, 2'b11});
    chk("up_second_dat", upo.dat, 512'hD5_D4D3_D2D1);
    step();
    chk("up_second_drain", upo.val, 0);

    // ---- down 64->8, one eop beat with mod=20
    dno.rdy = 1'b1;
    dni.val = 1'b1; dni.sop = 1'b1; dni.eop = 1'b1; dni.err = 1'b0;
    dni.dat = seq_bytes(64, 64); dni.mod = 6'd20; dni.ctl = 8'h3C;
    step();
    dni.val = 1'b0;
    for (int b = 0; b < 3; b++) begin
      tmp = seq_bytes(64 + b * 8, 8);
      chk("dn_part_val", dno.val, 1);
      chk("dn_part_dat", dno.dat, tmp[63:0]);
      chk("dn_part_sop_eop", {dno.sop, dno.eop}, {b == 0, b == 2});
      chk("dn_part_mod", dno.mod, (b == 2) ? 4 : 0);
      chk("dn_part_ctl_err", {dno.ctl, dno.err}, {8'h3C, 1'b0});
      if (b == 0) chk("dn_part_irdy_busy", dni.rdy, 0);
      step();
    end
    chk("dn_part_no_4th", dno.val, 0);
    step();
    chk("dn_part_idle", dno.val, 0);

    // ---- down 64->8, two 128-byte packets, output ready 1,0,0,1
    ib = 0; nb = 0; prev_stall = 1'b0; prev_snap = '0;
    tmp = seq_bytes(0, 64);
    dni.val = 1'b1; dni.dat = tmp; dni.sop = 1'b1; dni.eop = 1'b0;
    dni.err = 1'b1; dni.mod = '0; dni.ctl = 8'h10;
    for (int c = 0; c < 200 && nb < 32; c++) begin
      dno.rdy = ((c % 4) == 0) || ((c % 4) == 3);
      @(negedge i_clk);
      in_hs = dni.val && dni.rdy;
      snap  = {dno.val, dno.sop, dno.eop, dno.err, dno.mod, dno.ctl, dno.dat};
      if (prev_stall) chk("bp_stable", snap, prev_snap);
      if (dno.val && dno.rdy) begin
        tmp = seq_bytes(nb * 8, 8);
        chk("bp_dat", dno.dat, tmp[63:0]);
        chk("bp_err", dno.err, nb == 15);
        chk("bp_sop_eop", {dno.sop, dno.eop},
            {(nb == 0) || (nb == 16), (nb == 15) || (nb == 31)});
        chk("bp_ctl", dno.ctl, (nb < 16) ? 8'h10 : 8'h11);
        nb++;
      end
      prev_stall = dno.val && !dno.rdy;
      prev_snap  = snap;
      step();
      if (in_hs) begin
        ib++;
        if (ib < 4) begin
          tmp = seq_bytes(ib * 64, 64);
          dni.dat = tmp;
          dni.sop = (ib == 2);
          dni.eop = (ib == 1) || (ib == 3);
          dni.err = 1'b0;
          dni.ctl = (ib < 2) ? 8'h10 : 8'h11;
        end else begin
          dni.val = 1'b0;
        end
      end
    end
    chk("bp_beats", nb, 32);
    chk("bp_inputs", ib, 4);
    dno.rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      chk("bp_no_extra", dno.val, 0);
      step();
    end

    // ---- up 8->32, 64 continuous beats, output always ready
    nout = 0; idle = 0;
    for (int n = 0; n < 68; n++) begin
      if (n < 64) begin
        tmp = seq_bytes(n * 8, 8);
        tpi.val = 1'b1;
        tpi.dat = tmp[63:0];
        tpi.sop = (n % 8) == 0;
        tpi.eop = (n % 8) == 7;
        tpi.mod = '0;
        tpi.err = 1'b0;
        tpi.ctl = 8'(n / 8);
      end else begin
        tpi.val = 1'b0;
      end
      @(negedge i_clk);
      if (n < 64 && !tpi.rdy) idle++;
      if (tpo.val) begin
        tmp = seq_bytes(nout * 32, 32);
        chk("tp_dat", tpo.dat, tmp[255:0]);
        chk("tp_sop_eop", {tpo.sop, tpo.eop}, {(nout % 2) == 0, (nout % 2) == 1});
        chk("tp_mod_err", {tpo.mod, tpo.err}, 0);
        chk("tp_ctl", tpo.ctl, 8'(nout / 2));
        nout++;
      end
      step();
    end
    chk("tp_outputs", nout, 16);
    chk("tp_idle_cycles", idle, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
